// File: rtl/multicycle_control_if.sv
// Bundle of the fetch handshake, memory acknowledge and datapath strobes
// between the multi-cycle control unit and its surroundings.
//
// Handshake: an instruction transfers on a rising clock edge where both
// InstrValid and InstrReady are high. InstrReady is high only while the
// control unit is idle in FETCH. InstrValid seen while InstrReady is low is
// ignored.
interface multicycle_control_if #(
    parameter int INSTR_W = 32,
    parameter int ALUOP_W = 2,
    parameter int CNT_W   = 16
);
    logic [INSTR_W-1:0] Instruction;
    logic               InstrValid;
    logic               InstrReady;
    logic               MemAck;
    logic               RegDst;
    logic               ALUSrc;
    logic [ALUOP_W-1:0] ALUOp;
    logic               MemtoReg;
    logic               MemRead;
    logic               MemWrite;
    logic               RegWrite;
    logic               Busy;
    logic               IllegalOp;
    logic               MemErr;
    logic [CNT_W-1:0]   RetireCnt;
    logic [2:0]         DbgState;

    // Fetch stage / data memory side.
    modport master (
        output Instruction, InstrValid, MemAck,
        input  InstrReady, RegDst, ALUSrc, ALUOp, MemtoReg, MemRead, MemWrite,
               RegWrite, Busy, IllegalOp, MemErr, RetireCnt, DbgState
    );

    // Control unit side.
    modport slave (
        input  Instruction, InstrValid, MemAck,
        output InstrReady, RegDst, ALUSrc, ALUOp, MemtoReg, MemRead, MemWrite,
               RegWrite, Busy, IllegalOp, MemErr, RetireCnt, DbgState
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle control unit for the 8-bit one-hot opcode ISA.
// Sequences each accepted instruction through DECODE/EXEC/MEM/WB and drives
// registered datapath strobes that line up with the state they belong to.
// Handles data-memory stalls with a timeout, traps illegal opcodes and counts
// retired instructions. DbgState mirrors the current FSM state.
module multicycle_control #(
    parameter int INSTR_W     = 32,
    parameter int ALUOP_W     = 2,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic Clk,
    input  logic Reset,
    multicycle_control_if.slave bus
);

    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;

    localparam logic [7:0] OP_LOAD  = 8'h80;
    localparam logic [7:0] OP_STORE = 8'h40;
    localparam logic [7:0] OP_ADD   = 8'h20;
    localparam logic [7:0] OP_SUB   = 8'h10;
    localparam logic [7:0] OP_SHL   = 8'h08;
    localparam logic [7:0] OP_SHR   = 8'h04;

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_SHL = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_SHR = ALUOP_W'(3);

    localparam int                TCNT_W    = $clog2(MEM_TIMEOUT + 1);
    // Last MEM cycle index: MEM lasts at most MEM_TIMEOUT cycles.
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(MEM_TIMEOUT - 1);

    logic [2:0]         state, next_state;
    logic [7:0]         op_q, next_op;
    logic [TCNT_W-1:0]  tcnt;
    logic               accept;
    logic               mem_timeout;

    logic               d_legal, d_load, d_store, d_alu, d_imm;
    logic [ALUOP_W-1:0] d_aluop;
    logic               in_flight;

    logic               instr_ready_q, busy_q;
    logic               reg_dst_q, alu_src_q, mem_to_reg_q;
    logic [ALUOP_W-1:0] alu_op_q;
    logic               mem_read_q, mem_write_q, reg_write_q;
    logic               illegal_op_q, mem_err_q;
    logic [CNT_W-1:0]   retire_cnt_q;

    // Only the opcode byte of the instruction steers control.
    logic               unused_instr_bits;
    assign unused_instr_bits = ^bus.Instruction[INSTR_W-9:0];

    // Transfer condition and the opcode the FSM will hold next cycle.
    always_comb begin
        accept  = (state == FETCH) && instr_ready_q && bus.InstrValid;
        next_op = accept ? bus.Instruction[INSTR_W-1 -: 8] : op_q;
    end

    // Exact-match decode of the (next) opcode into control classes.
    always_comb begin
        d_legal = 1'b0;
        d_load  = 1'b0;
        d_store = 1'b0;
        d_alu   = 1'b0;
        d_imm   = 1'b0;
        d_aluop = ALU_ADD;
        case (next_op)
            OP_LOAD:  begin d_legal = 1'b1; d_load  = 1'b1; d_imm = 1'b1; end
            OP_STORE: begin d_legal = 1'b1; d_store = 1'b1; d_imm = 1'b1; end
            OP_ADD:   begin d_legal = 1'b1; d_alu   = 1'b1; d_aluop = ALU_ADD; end
            OP_SUB:   begin d_legal = 1'b1; d_alu   = 1'b1; d_aluop = ALU_SUB; end
            OP_SHL:   begin d_legal = 1'b1; d_alu   = 1'b1; d_imm = 1'b1; d_aluop = ALU_SHL; end
            OP_SHR:   begin d_legal = 1'b1; d_alu   = 1'b1; d_imm = 1'b1; d_aluop = ALU_SHR; end
            default:  d_legal = 1'b0;
        endcase
    end

    // Next-state sequencing including the memory stall/timeout exits.
    always_comb begin
        mem_timeout = (state == MEM) && !bus.MemAck && (tcnt == TCNT_LAST);
        next_state  = state;
        case (state)
            FETCH:   if (accept) next_state = DECODE;
            DECODE:  next_state = d_legal ? EXEC : FETCH;
            EXEC:    next_state = (d_load || d_store) ? MEM : WB;
            MEM: begin
                if (bus.MemAck)       next_state = d_load ? WB : FETCH;
                else if (mem_timeout) next_state = FETCH;
                else                  next_state = MEM;
            end
            WB:      next_state = FETCH;
            default: next_state = FETCH;
        endcase
        in_flight = (next_state != FETCH) && d_legal;
    end

    // State, opcode, stall counter and all registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= FETCH;
            op_q          <= 8'h00;
            tcnt          <= '0;
            instr_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            reg_dst_q     <= 1'b0;
            alu_src_q     <= 1'b0;
            alu_op_q      <= '0;
            mem_to_reg_q  <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            reg_write_q   <= 1'b0;
            illegal_op_q  <= 1'b0;
            mem_err_q     <= 1'b0;
            retire_cnt_q  <= '0;
        end else begin
            state         <= next_state;
            op_q          <= next_op;
            tcnt          <= ((state == MEM) && (next_state == MEM)) ? tcnt + TCNT_W'(1) : '0;
            instr_ready_q <= (next_state == FETCH);
            busy_q        <= (next_state != FETCH);
            reg_dst_q     <= in_flight && d_alu;
            alu_src_q     <= in_flight && d_imm;
            alu_op_q      <= in_flight ? d_aluop : '0;
            mem_to_reg_q  <= in_flight && d_load;
            mem_read_q    <= (next_state == MEM) && d_load;
            mem_write_q   <= (next_state == MEM) && d_store;
            reg_write_q   <= (next_state == WB);
            illegal_op_q  <= (next_state == DECODE) && !d_legal;
            mem_err_q     <= mem_timeout;
            if ((state == WB) || ((state == MEM) && bus.MemAck && (op_q == OP_STORE)))
                retire_cnt_q <= retire_cnt_q + CNT_W'(1);
        end
    end

    assign bus.InstrReady = instr_ready_q;
    assign bus.Busy       = busy_q;
    assign bus.RegDst     = reg_dst_q;
    assign bus.ALUSrc     = alu_src_q;
    assign bus.ALUOp      = alu_op_q;
    assign bus.MemtoReg   = mem_to_reg_q;
    assign bus.MemRead    = mem_read_q;
    assign bus.MemWrite   = mem_write_q;
    assign bus.RegWrite   = reg_write_q;
    assign bus.IllegalOp  = illegal_op_q;
    assign bus.MemErr     = mem_err_q;
    assign bus.RetireCnt  = retire_cnt_q;
    assign bus.DbgState   = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (MEM_TIMEOUT=15, CNT_W=2).
// Strobe vector layout: {RegDst, ALUSrc, ALUOp[1:0], MemtoReg, MemRead,
// MemWrite, RegWrite, IllegalOp, MemErr}. Cycle k means k clocks after accept.
module tb_multicycle_control;

    logic Clk = 1'b0;
    logic Reset;
    int   checks   = 0;
    int   failures = 0;
    logic [1:0] exp_cnt;

    multicycle_control_if #(.INSTR_W(32), .ALUOP_W(2), .CNT_W(2)) bus ();

    multicycle_control #(
        .INSTR_W(32), .ALUOP_W(2), .MEM_TIMEOUT(15), .CNT_W(2)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    wire [9:0] strobes = {bus.RegDst, bus.ALUSrc, bus.ALUOp, bus.MemtoReg,
                          bus.MemRead, bus.MemWrite, bus.RegWrite, bus.IllegalOp, bus.MemErr};

    // Clock generation.
    always #5 Clk = ~Clk;

    // Advance one clock; outputs are observed 1 ns after the edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; bus.InstrValid = 1'b0; bus.MemAck = 1'b0; bus.Instruction = '0;
        step(); step();
        checks++; if (strobes !== 10'b0) begin failures++; $display("FAIL reset_strobes: got %b want %b", strobes, 10'b0); end
        checks++; if (bus.RetireCnt !== 2'd0) begin failures++; $display("FAIL reset_cnt: got %0d want 0", bus.RetireCnt); end
        checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus.Busy); end
        Reset = 1'b0;
        step();
        checks++; if (bus.InstrReady !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", bus.InstrReady); end
        checks++; if (bus.DbgState !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", bus.DbgState); end
        exp_cnt = 2'd0;
    endtask

    // ADD; MemAck held high throughout to show it is ignored outside MEM.
    task automatic test_add();
        logic [9:0] exp_s [4];
        logic [2:0] exp_st [4];
        logic [1:0] want_cnt;
        exp_s  = '{10'b1000000000, 10'b1000000000, 10'b1000000100, 10'b0000000000};
        exp_st = '{3'd1, 3'd2, 3'd4, 3'd0};
        checks++; if (bus.InstrReady !== 1'b1) begin failures++; $display("FAIL add_ready_pre: got %b want 1", bus.InstrReady); end
        bus.Instruction = 32'h2000_0000; bus.InstrValid = 1'b1; bus.MemAck = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            bus.InstrValid = 1'b0;
            want_cnt = (c == 3) ? exp_cnt + 2'd1 : exp_cnt;
            checks++; if (strobes !== exp_s[c]) begin failures++; $display("FAIL add_strobes c%0d: got %b want %b", c + 1, strobes, exp_s[c]); end
            checks++; if (bus.DbgState !== exp_st[c]) begin failures++; $display("FAIL add_state c%0d: got %0d want %0d", c + 1, bus.DbgState, exp_st[c]); end
            checks++; if (bus.InstrReady !== (c == 3)) begin failures++; $display("FAIL add_ready c%0d: got %b want %b", c + 1, bus.InstrReady, c == 3); end
            checks++; if (bus.Busy !== (c != 3)) begin failures++; $display("FAIL add_busy c%0d: got %b want %b", c + 1, bus.Busy, c != 3); end
            checks++; if (bus.RetireCnt !== want_cnt) begin failures++; $display("FAIL add_cnt c%0d: got %0d want %0d", c + 1, bus.RetireCnt, want_cnt); end
        end
        bus.MemAck = 1'b0;
        exp_cnt = exp_cnt + 2'd1;
    endtask

    // LOAD with MemAck on the third MEM cycle.
    task automatic test_load();
        logic [9:0] exp_s [7];
        logic [2:0] exp_st [7];
        logic [1:0] want_cnt;
        exp_s  = '{10'b0100100000, 10'b0100100000, 10'b0100110000, 10'b0100110000,
                   10'b0100110000, 10'b0100100100, 10'b0000000000};
        exp_st = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
        bus.Instruction = 32'h8000_0004; bus.InstrValid = 1'b1; bus.MemAck = 1'b0;
        for (int c = 0; c < 7; c++) begin
            step();
            bus.InstrValid = 1'b0;
            bus.MemAck = (c == 4);
            want_cnt = (c == 6) ? exp_cnt + 2'd1 : exp_cnt;
            checks++; if (strobes !== exp_s[c]) begin failures++; $display("FAIL load_strobes c%0d: got %b want %b", c + 1, strobes, exp_s[c]); end
            checks++; if (bus.DbgState !== exp_st[c]) begin failures++; $display("FAIL load_state c%0d: got %0d want %0d", c + 1, bus.DbgState, exp_st[c]); end
            checks++; if (bus.InstrReady !== (c == 6)) begin failures++; $display("FAIL load_ready c%0d: got %b want %b", c + 1, bus.InstrReady, c == 6); end
            checks++; if (bus.RetireCnt !== want_cnt) begin failures++; $display("FAIL load_cnt c%0d: got %0d want %0d", c + 1, bus.RetireCnt, want_cnt); end
        end
        bus.MemAck = 1'b0;
        exp_cnt = exp_cnt + 2'd1;
    endtask

    // STORE: either no MemAck (timeout after 15 MEM cycles) or MemAck on the 15th.
    task automatic test_store(input bit ack_last);
        logic [9:0] want_s;
        logic [1:0] want_cnt;
        bus.Instruction = 32'h4000_0000; bus.InstrValid = 1'b1; bus.MemAck = 1'b0;
        for (int c = 0; c < 19; c++) begin
            step();
            bus.InstrValid = 1'b0;
            bus.MemAck = ack_last && (c == 16);
            if (c < 2)        want_s = 10'b0100000000;
            else if (c < 17)  want_s = 10'b0100001000;
            else if (c == 17) want_s = ack_last ? 10'b0000000000 : 10'b0000000001;
            else              want_s = 10'b0000000000;
            want_cnt = (ack_last && c >= 17) ? exp_cnt + 2'd1 : exp_cnt;
            checks++; if (strobes !== want_s) begin failures++; $display("FAIL store%0d_strobes c%0d: got %b want %b", ack_last, c + 1, strobes, want_s); end
            checks++; if (bus.InstrReady !== (c >= 17)) begin failures++; $display("FAIL store%0d_ready c%0d: got %b want %b", ack_last, c + 1, bus.InstrReady, c >= 17); end
            checks++; if (bus.RetireCnt !== want_cnt) begin failures++; $display("FAIL store%0d_cnt c%0d: got %0d want %0d", ack_last, c + 1, bus.RetireCnt, want_cnt); end
        end
        bus.MemAck = 1'b0;
        if (ack_last) exp_cnt = exp_cnt + 2'd1;
    endtask

    task automatic test_illegal(input logic [7:0] op);
        bus.Instruction = {op, 24'h00_0000}; bus.InstrValid = 1'b1;
        step();
        bus.InstrValid = 1'b0;
        checks++; if (strobes !== 10'b0000000010) begin failures++; $display("FAIL illegal_%h_decode: got %b want %b", op, strobes, 10'b0000000010); end
        checks++; if (bus.InstrReady !== 1'b0) begin failures++; $display("FAIL illegal_%h_ready1: got %b want 0", op, bus.InstrReady); end
        checks++; if (bus.Busy !== 1'b1) begin failures++; $display("FAIL illegal_%h_busy1: got %b want 1", op, bus.Busy); end
        step();
        checks++; if (strobes !== 10'b0) begin failures++; $display("FAIL illegal_%h_after: got %b want %b", op, strobes, 10'b0); end
        checks++; if (bus.InstrReady !== 1'b1) begin failures++; $display("FAIL illegal_%h_ready2: got %b want 1", op, bus.InstrReady); end
        checks++; if (bus.DbgState !== 3'd0) begin failures++; $display("FAIL illegal_%h_state: got %0d want 0", op, bus.DbgState); end
        checks++; if (bus.RetireCnt !== exp_cnt) begin failures++; $display("FAIL illegal_%h_cnt: got %0d want %0d", op, bus.RetireCnt, exp_cnt); end
    endtask

    // SHL, SHR, SUB with InstrValid never dropped; count wraps 3 -> 0.
    task automatic test_back_to_back();
        logic [7:0] ops [3];
        logic [9:0] dec [3];
        logic [9:0] want_s;
        logic [1:0] want_cnt;
        ops = '{8'h08, 8'h04, 8'h10};
        dec = '{10'b1110000000, 10'b1111000000, 10'b1001000000};
        checks++; if (exp_cnt !== 2'd3 || bus.RetireCnt !== 2'd3) begin failures++; $display("FAIL b2b_precount: got %0d want 3", bus.RetireCnt); end
        bus.InstrValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.Instruction = {ops[i], 24'h00_0000};
            for (int c = 0; c < 4; c++) begin
                step();
                if (c < 2)       want_s = dec[i];
                else if (c == 2) want_s = dec[i] | 10'b0000000100;
                else             want_s = 10'b0;
                want_cnt = (c == 3) ? exp_cnt + 2'd1 : exp_cnt;
                checks++; if (strobes !== want_s) begin failures++; $display("FAIL b2b_%0d_strobes c%0d: got %b want %b", i, c + 1, strobes, want_s); end
                checks++; if (bus.InstrReady !== (c == 3)) begin failures++; $display("FAIL b2b_%0d_ready c%0d: got %b want %b", i, c + 1, bus.InstrReady, c == 3); end
                checks++; if (bus.RetireCnt !== want_cnt) begin failures++; $display("FAIL b2b_%0d_cnt c%0d: got %0d want %0d", i, c + 1, bus.RetireCnt, want_cnt); end
            end
            exp_cnt = exp_cnt + 2'd1;
        end
        bus.InstrValid = 1'b0;
    endtask

    // Reset held 3 cycles while a LOAD waits in MEM.
    task automatic test_reset_mid_load();
        bus.Instruction = 32'h8000_0004; bus.InstrValid = 1'b1; bus.MemAck = 1'b0;
        step();
        bus.InstrValid = 1'b0;
        step(); step();
        checks++; if (strobes !== 10'b0100110000) begin failures++; $display("FAIL rst_mid_inmem: got %b want %b", strobes, 10'b0100110000); end
        Reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (strobes !== 10'b0) begin failures++; $display("FAIL rst_mid_strobes c%0d: got %b want %b", c, strobes, 10'b0); end
            checks++; if (bus.RetireCnt !== 2'd0) begin failures++; $display("FAIL rst_mid_cnt c%0d: got %0d want 0", c, bus.RetireCnt); end
            checks++; if (bus.InstrReady !== 1'b0) begin failures++; $display("FAIL rst_mid_ready c%0d: got %b want 0", c, bus.InstrReady); end
            checks++; if (bus.DbgState !== 3'd0) begin failures++; $display("FAIL rst_mid_state c%0d: got %0d want 0", c, bus.DbgState); end
        end
        Reset = 1'b0;
        exp_cnt = 2'd0;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++; if (bus.InstrReady !== 1'b1) begin failures++; $display("FAIL rst_mid_release_ready c%0d: got %b want 1", c, bus.InstrReady); end
            checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL rst_mid_release_busy c%0d: got %b want 0", c, bus.Busy); end
            checks++; if (strobes !== 10'b0) begin failures++; $display("FAIL rst_mid_release_strobes c%0d: got %b want %b", c, strobes, 10'b0); end
            checks++; if (bus.RetireCnt !== exp_cnt) begin failures++; $display("FAIL rst_mid_release_cnt c%0d: got %0d want 0", c, bus.RetireCnt); end
        end
    endtask

    // Scenario sequence and final report.
    initial begin
        test_reset();
        test_add();
        test_load();
        test_store(1'b0);
        test_store(1'b1);
        test_illegal(8'h00);
        test_illegal(8'h30);
        test_back_to_back();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Run-time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
